// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: CPU-port and memory-port bundle of the unified memory arbiter
// Ports: if_* instruction-fetch read port, dm_* data-memory read/write port,
//   mem_* single-port memory side; slave = arbiter view, master = CPU/memory view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              dm_stall;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between the IF and DM ports
// Ports: clk, rst_n (sync, active-low), bus (unified_mem_arbiter_if.slave).
//   DM wins arbitration unless it has won MAX_DSTREAK times in a row with IF waiting;
//   an access with no mem_ready for TIMEOUT busy cycles completes with err.
module unified_mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input logic clk,
  input logic rst_n,
  unified_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} stateT;
  stateT         state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tmoCnt;
  logic          dmWins;
  logic          timedOut;
  assign dmWins       = bus.dm_req && !(bus.if_req && streak == SW'(MAX_DSTREAK));
  assign timedOut     = tmoCnt == TW'(TIMEOUT - 1);
  // Stalls are held low during reset so the pipeline sees a quiet arbiter.
  assign bus.if_stall = rst_n & bus.if_req & ~bus.if_ack;
  assign bus.dm_stall = rst_n & bus.dm_req & ~bus.dm_ack;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      streak        <= '0;
      tmoCnt        <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.dm_ack <= 1'b0;
      bus.err    <= 1'b0;
      case (state)
        IDLE: begin
          if (dmWins) begin
            state         <= BUSY_D;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            streak        <= bus.if_req ? streak + SW'(1) : '0;
          end else if (bus.if_req) begin
            state         <= BUSY_I;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            streak        <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ready || timedOut) begin
            state       <= DONE;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            tmoCnt      <= '0;
            bus.err     <= !bus.mem_ready;
            if (state == BUSY_I) begin
              bus.if_ack <= 1'b1;
              if (bus.mem_ready) bus.if_rdata <= bus.mem_rdata;
            end else begin
              bus.dm_ack <= 1'b1;
              if (bus.mem_ready && !bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
            end
          end else begin
            tmoCnt <= tmoCnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;
  int   n;
  logic [9:0] expSeq = 10'b10_0001_0000;
  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
  unified_mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic logic anyOut();
    return b.if_ack | b.dm_ack | b.err | b.mem_req | b.mem_we | b.if_stall | b.dm_stall
         | (|b.mem_addr) | (|b.mem_wdata) | (|b.if_rdata) | (|b.dm_rdata);
  endfunction
  initial begin
    rst_n = 1'b0;
    b.if_req = 1'b1; b.if_addr = 32'h4;
    b.dm_req = 1'b1; b.dm_we = 1'b0; b.dm_addr = 32'h44; b.dm_wdata = '0;
    b.mem_rdata = 32'h1234_5678; b.mem_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_outputs", 32'(anyOut()), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("rst_first_req", 32'(b.mem_req), 32'd1);
    chk("rst_first_is_dm", b.mem_addr, 32'h44);
    b.if_req = 1'b0;
    tick();
    chk("rst_dm_ack", 32'(b.dm_ack), 32'd1);
    chk("rst_dm_rdata", b.dm_rdata, 32'h1234_5678);
    b.dm_req = 1'b0;
    tick();
    b.if_req = 1'b1; b.if_addr = 32'h10; b.mem_rdata = 32'h8C01_0004;
    tick();
    chk("if_mem_req", 32'(b.mem_req), 32'd1);
    chk("if_mem_addr", b.mem_addr, 32'h10);
    chk("if_stall_busy", 32'(b.if_stall), 32'd1);
    tick();
    chk("if_ack", 32'(b.if_ack), 32'd1);
    chk("if_rdata", b.if_rdata, 32'h8C01_0004);
    chk("if_no_dm_ack", 32'(b.dm_ack), 32'd0);
    b.if_req = 1'b0;
    tick();
    chk("if_ack_once", 32'(b.if_ack), 32'd0);
    b.if_req = 1'b1; b.if_addr = 32'h20;
    b.dm_req = 1'b1; b.dm_we = 1'b1; b.dm_addr = 32'h40; b.dm_wdata = 32'hDEAD_BEEF;
    b.mem_rdata = 32'h1111_1111;
    #1;
    chk("both_stall_c0", 32'(b.if_stall), 32'd1);
    tick();
    chk("both_c1_we", 32'(b.mem_we), 32'd1);
    chk("both_c1_addr", b.mem_addr, 32'h40);
    chk("both_c1_wdata", b.mem_wdata, 32'hDEAD_BEEF);
    chk("both_stall_c1", 32'(b.if_stall), 32'd1);
    tick();
    chk("both_c2_dm_ack", 32'(b.dm_ack), 32'd1);
    chk("both_c2_if_ack", 32'(b.if_ack), 32'd0);
    chk("both_c2_dm_rdata_kept", b.dm_rdata, 32'h1234_5678);
    chk("both_stall_c2", 32'(b.if_stall), 32'd1);
    b.dm_req = 1'b0; b.dm_we = 1'b0;
    tick();
    chk("both_c3_idle", 32'(b.mem_req), 32'd0);
    chk("both_stall_c3", 32'(b.if_stall), 32'd1);
    tick();
    chk("both_c4_req", 32'(b.mem_req), 32'd1);
    chk("both_c4_addr", b.mem_addr, 32'h20);
    chk("both_c4_we", 32'(b.mem_we), 32'd0);
    chk("both_c4_wdata", b.mem_wdata, 32'd0);
    chk("both_stall_c4", 32'(b.if_stall), 32'd1);
    tick();
    chk("both_c5_if_ack", 32'(b.if_ack), 32'd1);
    chk("both_c5_if_rdata", b.if_rdata, 32'h1111_1111);
    chk("both_stall_c5", 32'(b.if_stall), 32'd0);
    b.if_req = 1'b0;
    tick();
    b.if_addr = 32'h100; b.dm_addr = 32'h200; b.dm_we = 1'b0;
    b.if_req = 1'b1; b.dm_req = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      tick();
      chk("ack_onehot", 32'(b.if_ack & b.dm_ack), 32'd0);
      if (b.mem_req) begin
        chk("grant_order", 32'(b.mem_addr == 32'h100), 32'(expSeq[n]));
        n++;
      end
    end
    chk("grant_count", n, 32'd10);
    b.if_req = 1'b0; b.dm_req = 1'b0;
    tick();
    tick();
    b.mem_ready = 1'b0;
    b.dm_req = 1'b1; b.dm_addr = 32'h80;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("wait_stable_req", 32'(b.mem_req), 32'd1);
      chk("wait_stable_addr", b.mem_addr, 32'h80);
      chk("wait_no_ack", 32'(b.dm_ack), 32'd0);
      tick();
    end
    b.mem_ready = 1'b1; b.mem_rdata = 32'hCAFE_F00D;
    chk("wait_req_at_ready", 32'(b.mem_req), 32'd1);
    tick();
    chk("wait_dm_ack", 32'(b.dm_ack), 32'd1);
    chk("wait_dm_rdata", b.dm_rdata, 32'hCAFE_F00D);
    chk("wait_no_err", 32'(b.err), 32'd0);
    b.dm_req = 1'b0; b.mem_ready = 1'b0;
    tick();
    b.dm_req = 1'b1; b.dm_addr = 32'h84;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("tmo_busy", 32'({b.mem_req, b.dm_ack}), 32'd2);
    end
    tick();
    chk("tmo_dm_ack", 32'(b.dm_ack), 32'd1);
    chk("tmo_err", 32'(b.err), 32'd1);
    chk("tmo_mem_req", 32'(b.mem_req), 32'd0);
    chk("tmo_rdata_kept", b.dm_rdata, 32'hCAFE_F00D);
    b.dm_req = 1'b0; b.mem_ready = 1'b1;
    repeat (2) begin
      tick();
      chk("idle_ready_ignored", 32'({b.dm_ack, b.if_ack, b.err, b.mem_req}), 32'd0);
    end
    b.mem_ready = 1'b0;
    b.dm_req = 1'b1;
    repeat (3) tick();
    chk("abort_busy", 32'(b.mem_req), 32'd1);
    rst_n = 1'b0; b.dm_req = 1'b0;
    tick();
    chk("abort_quiet", 32'({b.mem_req, b.dm_ack, b.err}), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("abort_no_ack", 32'({b.mem_req, b.dm_ack, b.err}), 32'd0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
